// File: rtl/w_ptr_and_full_pkg.sv
// Shared defaults and pointer helpers for the async FIFO pointer blocks.
package w_ptr_and_full_pkg;

    localparam int ADDR_W_DEF    = 5;
    localparam int AF_MARGIN_DEF = 4;
    localparam int DEPTH_DEF     = 2 ** ADDR_W_DEF;
    localparam int PTR_W_DEF     = ADDR_W_DEF + 1;

    // Width-agnostic binary-to-gray; callers truncate to their pointer width.
    function automatic logic [31:0] bin2gray32(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/w_ptr_and_full_if.sv
// Write-side FIFO bus: producer request, synchronised read pointer and write-side status.
interface w_ptr_and_full_if
    import w_ptr_and_full_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr_en;
    logic [ADDR_W:0]   wq2_rptr;
    logic              wr_inc;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_ptr;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              overflow;

    modport master (
        output wr_en, wq2_rptr,
        input  wr_inc, wr_addr, wr_ptr, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, wq2_rptr,
        output wr_inc, wr_addr, wr_ptr, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/w_ptr_and_full_gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module w_ptr_and_full_gray2bin #(
    parameter int W = 6
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign bin[gi] = ^gray[W-1:gi];
        end
    endgenerate
endmodule

// File: rtl/w_ptr_and_full.sv
// Write-side pointer, full/almost_full and level logic of the async FIFO.
// Optional sticky overflow flag is built only when WPTR_OVERFLOW_EN is defined.
module w_ptr_and_full
    import w_ptr_and_full_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AF_MARGIN = AF_MARGIN_DEF
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    w_ptr_and_full_if.slave   bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);

    logic [PTR_W-1:0] wbin_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_level_reg;
    logic             full_reg;
    logic             almost_full_reg;

    logic             wr_inc;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] level_next;
    logic [PTR_W-1:0] full_gray;

    w_ptr_and_full_gray2bin #(.W(PTR_W)) u_gray2bin (
        .gray (bus.wq2_rptr),
        .bin  (rbin)
    );

    // A write strobe during reset would land in RAM but never be counted, so suppress it.
    assign wr_inc     = bus.wr_en & ~full_reg & ~wr_rst;
    assign wbin_next  = wbin_reg + {{(PTR_W-1){1'b0}}, wr_inc};
    assign wgray_next = PTR_W'(bin2gray32(32'(wbin_next)));
    assign level_next = wbin_next - rbin;

    // Full when the write pointer has lapped the read pointer exactly once:
    // in gray that means the top two bits inverted, the rest equal.
    assign full_gray  = {~bus.wq2_rptr[ADDR_W:ADDR_W-1], bus.wq2_rptr[ADDR_W-2:0]};

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin_reg        <= '0;
            wr_ptr_reg      <= '0;
            wr_level_reg    <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
        end else begin
            wbin_reg        <= wbin_next;
            wr_ptr_reg      <= wgray_next;
            wr_level_reg    <= level_next;
            full_reg        <= (wgray_next == full_gray);
            almost_full_reg <= (level_next >= AF_LEVEL);
        end
    end

`ifdef WPTR_OVERFLOW_EN
    logic overflow_reg;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_reg | (bus.wr_en & full_reg);
        end
    end

    assign bus.overflow = overflow_reg;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.wr_inc      = wr_inc;
    assign bus.wr_addr     = wbin_reg[ADDR_W-1:0];
    assign bus.wr_ptr      = wr_ptr_reg;
    assign bus.full        = full_reg;
    assign bus.almost_full = almost_full_reg;
    assign bus.wr_level    = wr_level_reg;

endmodule

// File: tb/tb_w_ptr_and_full.sv
// Scoreboard bench for w_ptr_and_full (ADDR_W=5, AF_MARGIN=4): driver pushes expectations, monitor checks.
module tb_w_ptr_and_full;

    localparam int ADDR_W = 5;

    typedef struct {
        string      name;
        logic       inc;        // wr_inc before the edge
        logic [4:0] addr_pre;   // wr_addr before the edge
        logic [5:0] ptr;
        logic [4:0] addr;
        logic       full;
        logic       af;
        logic [5:0] lvl;
        logic       ovf;
        bit         chk_step;   // check single-bit gray step
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    w_ptr_and_full_if #(.ADDR_W(ADDR_W)) bus ();

    w_ptr_and_full #(.ADDR_W(ADDR_W), .AF_MARGIN(4)) dut (
        .wr_clk (clk),
        .wr_rst (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   drv_done = 0;

    // Reference state: counts of accepted writes and of reads, as plain integers.
    int   wcnt = 0;
    int   rcount = 0;
    logic m_full = 1'b0;
    logic m_ovf = 1'b0;

    function automatic logic [5:0] to_gray(input int v);
        logic [5:0] b;
        b = v[5:0];
        return b ^ (b >> 1);
    endfunction

    task automatic cycle(input logic r, input logic en, input string nm, input bit step);
        exp_t e;
        int   occ;
        @(negedge clk);
        rst          = r;
        bus.wr_en    = en;
        bus.wq2_rptr = to_gray(rcount % 64);
        e.name       = nm;
        e.chk_step   = step;
        e.addr_pre   = 5'(wcnt % 32);
        e.inc        = en & ~r & ~m_full;
        if (r) begin
            wcnt   = 0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            e.ptr = '0; e.addr = '0; e.full = 1'b0; e.af = 1'b0; e.lvl = '0; e.ovf = 1'b0;
        end else begin
`ifdef WPTR_OVERFLOW_EN
            m_ovf = m_ovf | (en & m_full);
`endif
            if (e.inc) wcnt++;
            occ    = wcnt - rcount;
            m_full = (occ == 32);
            e.ptr  = to_gray(wcnt % 64);
            e.addr = 5'(wcnt % 32);
            e.full = m_full;
            e.af   = (occ >= 28);
            e.lvl  = 6'(occ);
            e.ovf  = m_ovf;
        end
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: samples the combinational strobe mid-cycle and the registered outputs after the edge.
    initial begin
        logic       s_inc;
        logic [4:0] s_addr;
        logic [5:0] prev_ptr;
        exp_t       e;
        prev_ptr = '0;
        forever begin
            @(negedge clk);
            #2;
            s_inc  = bus.wr_inc;
            s_addr = bus.wr_addr;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".wr_inc"},      32'(s_inc),           32'(e.inc));
                chk({e.name, ".wr_addr_pre"}, 32'(s_addr),          32'(e.addr_pre));
                chk({e.name, ".wr_ptr"},      32'(bus.wr_ptr),      32'(e.ptr));
                chk({e.name, ".wr_addr"},     32'(bus.wr_addr),     32'(e.addr));
                chk({e.name, ".full"},        32'(bus.full),        32'(e.full));
                chk({e.name, ".almost_full"}, 32'(bus.almost_full), 32'(e.af));
                chk({e.name, ".wr_level"},    32'(bus.wr_level),    32'(e.lvl));
                chk({e.name, ".overflow"},    32'(bus.overflow),    32'(e.ovf));
                if (e.chk_step)
                    chk({e.name, ".gray_step"}, $countones(bus.wr_ptr ^ prev_ptr), 32'(e.inc));
                $display("txn %-10s inc=%0b ptr=%b addr=%0d full=%0b af=%0b lvl=%0d ovf=%0b",
                         e.name, s_inc, bus.wr_ptr, bus.wr_addr, bus.full, bus.almost_full,
                         bus.wr_level, bus.overflow);
            end
            prev_ptr = bus.wr_ptr;
        end
    end

    // Driver: directed phases.
    initial begin
        bus.wr_en    = 1'b0;
        bus.wq2_rptr = '0;

        repeat (2) cycle(1'b1, 1'b1, "reset", 0);
        cycle(1'b0, 1'b0, "post_rst", 0);

        rcount = 0;
        for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, "fill", 0);
        for (int i = 0; i < 3; i++)  cycle(1'b0, 1'b1, "wr_full", 0);

        rcount = 1;
        cycle(1'b0, 1'b0, "drain", 0);
        cycle(1'b0, 1'b1, "refill", 0);

        rcount = 0;
        cycle(1'b1, 1'b0, "reset2", 0);
        for (int i = 0; i < 64; i++) begin
            rcount = wcnt;
            cycle(1'b0, 1'b1, "wrap", 1);
        end

        rcount = 0;
        cycle(1'b1, 1'b0, "reset3", 0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, "burst", 0);
        cycle(1'b1, 1'b1, "mid_rst", 0);
        cycle(1'b0, 1'b0, "idle", 0);

        drv_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (drv_done);
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue: got %0d pending expected 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
